mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multi-cycle control FSM. Consumes its IRWrite / AdrSrc / memWrite strobes and drives a single shared instruction/data memory port over a req/ack handshake.
- Holds the Instruction, OldPC and Data registers.
- Returns `stall` so the control FSM holds its state until each access completes. This adds variable-latency memory support to the multi-cycle core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum REQ cycles without ack before a fault (range 1..255).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ir_write  in  1  fetch request (IRWrite from controller).
- adr_src  in  1  data access request; address taken from alu_result.
- mem_write  in  1  store qualifier; only valid with adr_src=1.
- pc  in  ADDR_W  current PC.
- alu_result  in  ADDR_W  data address (ALUOut register).
- write_data  in  DATA_W  store data (rs2 register).
- instr  out  DATA_W  Instruction register.
- old_pc  out  ADDR_W  OldPC register.
- data  out  DATA_W  Data register (load result).
- stall  out  1  controller must hold its current state.
- fault  out  1  sticky bus error or timeout.
- bus_req  out  1  request valid.
- bus_we  out  1  write enable.
- bus_addr  out  ADDR_W  request address.
- bus_wdata  out  DATA_W  write data.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.
- bus_ack  in  1  transfer complete.
- bus_err  in  1  transfer failed; ends the transfer like ack.

Behaviour:
- Reset (asynchronous, active-high): all outputs and registers are 0 and state=IDLE. Reset mid-transaction drops bus_req in the same instant and discards any captured data.
- Request: `req = ir_write | adr_src`.
- Operation kind is latched at IDLE->REQ:
  - FETCH if ir_write=1. ir_write takes priority; simultaneous ir_write&adr_src is illegal and is treated as fetch.
  - STORE if adr_src&mem_write.
  - LOAD otherwise.
- The address is latched at IDLE->REQ: alu_result when adr_src=1 (and not fetch), else pc. The op's write data is latched at the same edge.
- Bus outputs are registered and stable while bus_req=1. bus_we=1 only for STORE.
- State IDLE:
  - req=1: go to REQ; stall=1.
  - req=0: stall=0.
- State REQ:
  - bus_req=1, stall=1.
  - On bus_ack: capture bus_rdata into an internal holding register; go to DONE.
  - On bus_err (wins over ack in the same cycle): set fault; go to HALT.
  - Timeout counter: cleared on entry, increments each REQ cycle. When it reaches TIMEOUT with no ack, set fault and go to HALT.
- State DONE (exactly one cycle):
  - stall=0, bus_req=0.
  - At the exit edge:
    - FETCH: instr <= holding register, old_pc <= pc. The controller's PC update occurs at this same edge, so old_pc gets the pre-increment PC.
    - LOAD: data <= holding register.
    - STORE: no register update.
  - Go to IDLE.
- State HALT: stall=1 permanently, bus_req=0, fault=1. Only reset exits.
- Latency: minimum access is 3 cycles (IDLE, REQ with ack on its first cycle, DONE); each extra REQ cycle adds 1.
- Back-to-back: a request present in the IDLE cycle after DONE starts a new transaction with no gap cycle.
- req deasserting during REQ is a controller violation. The transaction still completes and no register is updated. instr/old_pc/data update only at DONE.
- bus_ack while in IDLE or DONE is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: timeout counter and timeout fault path present as described.
- Undefined: no counter; REQ waits indefinitely for ack/err. fault is set only by bus_err. TIMEOUT is unused.

Decomposition:
- Shared package `mem_access_pkg` holds:
  - state encoding: IDLE=0, REQ=1, DONE=2, HALT=3;
  - op encoding: FETCH=0, LOAD=1, STORE=2;
  - default TIMEOUT constant.
- One sub-module: `mem_timeout_ctr` (clear, enable, terminal-count output), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
1. Fetch, ack on first REQ cycle: pc=0x100, bus_rdata=0x00500093 -> bus_addr=0x100, bus_we=0; stall high 2 cycles then low 1; instr=0x00500093, old_pc=0x100.
2. Load with 4-cycle ack delay: adr_src=1, alu_result=0x2004, rdata=0xDEADBEEF -> bus_req held 4 cycles; data=0xDEADBEEF after DONE; instr unchanged.
3. Store: adr_src=1, mem_write=1, alu_result=0x3000, write_data=0x12345678 -> bus_we=1, bus_wdata=0x12345678; data unchanged.
4. Timeout (MEM_TIMEOUT_EN, TIMEOUT=15), no ack -> fault=1 after 15 REQ cycles; bus_req=0, stall stuck at 1; ack then ignored.
5. bus_err on REQ cycle 2 -> fault=1, HALT; rst pulse mid-HALT -> all outputs 0; a following fetch succeeds.
6. Back-to-back fetch then load (ack immediate each) -> second bus_req rises the cycle after DONE; rst asserted mid-REQ drops bus_req with no instr update.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access stage: FSM states, access kinds,
// the default timeout and the access-kind decode used at request time.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        HALT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } op_t;

    localparam int DEFAULT_TIMEOUT = 15;

    // Fetch wins when both strobes are raised; otherwise the access is a data access.
    function automatic op_t decode_op(input logic ir_write, input logic mem_write);
        if (ir_write)
            return FETCH;
        else if (mem_write)
            return STORE;
        else
            return LOAD;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts REQ cycles of one bus transfer; tc flags the last cycle allowed before a fault.
module mem_timeout_ctr
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [7:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_reg <= '0;
        else if (clear)
            count_reg <= '0;
        else if (enable)
            count_reg <= count_reg + 8'd1;
    end

    assign tc = (count_reg == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multi-cycle core: runs one req/ack transfer per controller strobe,
// owns the Instruction/OldPC/Data registers and stalls the controller. MEM_TIMEOUT_EN adds a REQ timeout.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_write,
    input  logic              adr_src,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] old_pc,
    output logic [DATA_W-1:0] data,
    output logic              stall,
    output logic              fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err
);

    state_t            state_reg, state_next;
    op_t               op_reg;
    logic              req, timeout_hit, viol_reg;
    logic              bus_req_reg, bus_we_reg;
    logic [ADDR_W-1:0] bus_addr_reg, old_pc_reg;
    logic [DATA_W-1:0] bus_wdata_reg, hold_reg, instr_reg, data_reg;

    assign req = ir_write | adr_src;

`ifdef MEM_TIMEOUT_EN
    logic tc;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg != REQ),
        .enable (state_reg == REQ),
        .tc     (tc)
    );

    assign timeout_hit = (state_reg == REQ) & tc;
`else
    // No limit on REQ: a zero TIMEOUT is outside the legal range, so this is constant 0.
    assign timeout_hit = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = REQ;
            REQ: begin
                if (bus_err)          state_next = HALT;
                else if (bus_ack)     state_next = DONE;
                else if (timeout_hit) state_next = HALT;
            end
            DONE:    state_next = IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        fault = 1'b0;
        case (state_reg)
            IDLE: stall = req;
            REQ:  stall = 1'b1;
            DONE: stall = 1'b0;
            HALT: begin
                stall = 1'b1;
                fault = 1'b1;
            end
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg        <= FETCH;
            viol_reg      <= 1'b0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            hold_reg      <= '0;
            instr_reg     <= '0;
            old_pc_reg    <= '0;
            data_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: if (req) begin
                    op_reg        <= decode_op(ir_write, mem_write);
                    viol_reg      <= 1'b0;
                    bus_req_reg   <= 1'b1;
                    bus_we_reg    <= (decode_op(ir_write, mem_write) == STORE);
                    bus_addr_reg  <= (ir_write | ~adr_src) ? pc : alu_result;
                    bus_wdata_reg <= write_data;
                end
                REQ: begin
                    // A controller that drops its strobe mid-transfer forfeits the result.
                    if (!req)
                        viol_reg <= 1'b1;
                    if (bus_ack & ~bus_err)
                        hold_reg <= bus_rdata;
                    if (bus_ack | bus_err | timeout_hit) begin
                        bus_req_reg <= 1'b0;
                        bus_we_reg  <= 1'b0;
                    end
                end
                DONE: if (!viol_reg) begin
                    // The controller advances PC on this same edge, so pc is still the fetch address.
                    if (op_reg == FETCH) begin
                        instr_reg  <= hold_reg;
                        old_pc_reg <= pc;
                    end else if (op_reg == LOAD) begin
                        data_reg <= hold_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr     = instr_reg;
    assign old_pc    = old_pc_reg;
    assign data      = data_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, random transactions against a simple
// register model, and hand sequences for bus error, timeout/long wait and reset mid-transfer.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          ir_write, adr_src, mem_write;
    logic [AW-1:0] pc, alu_result;
    logic [DW-1:0] write_data;
    logic [DW-1:0] instr, data;
    logic [AW-1:0] old_pc;
    logic          stall, fault, bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic          bus_ack, bus_err;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_write   (ir_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .pc         (pc),
        .alu_result (alu_result),
        .write_data (write_data),
        .instr      (instr),
        .old_pc     (old_pc),
        .data       (data),
        .stall      (stall),
        .fault      (fault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err)
    );

    typedef struct {
        logic        iw, as, mw;
        logic [31:0] pcv, alu, wd, rd;
        int          n_req;
        bit          drop;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_instr, e_old_pc, e_data;
    } vec_t;

    vec_t        vecs[8];
    vec_t        v;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_instr, m_old_pc, m_data;
    int          op, cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clear_strobes();
        ir_write  = 1'b0;
        adr_src   = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " instr"},     instr,     32'h0);
        chk({tag, " old_pc"},    old_pc,    32'h0);
        chk({tag, " data"},      data,      32'h0);
        chk({tag, " fault"},     fault,     32'h0);
        chk({tag, " bus_req"},   bus_req,   32'h0);
        chk({tag, " bus_we"},    bus_we,    32'h0);
        chk({tag, " bus_addr"},  bus_addr,  32'h0);
        chk({tag, " bus_wdata"}, bus_wdata, 32'h0);
    endtask

    // Entered at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_vec(input string tag, input vec_t t);
        ir_write   = t.iw;
        adr_src    = t.as;
        mem_write  = t.mw;
        pc         = t.pcv;
        alu_result = t.alu;
        write_data = t.wd;
        bus_ack    = 1'b0;
        bus_err    = 1'b0;
        #1 chk({tag, " idle stall"}, stall, 32'h1);
        @(posedge clk);
        for (int k = 1; k <= t.n_req; k++) begin
            @(negedge clk);
            chk($sformatf("%s req%0d bus_req", tag, k), bus_req, 32'h1);
            chk($sformatf("%s req%0d stall", tag, k), stall, 32'h1);
            chk($sformatf("%s req%0d bus_addr", tag, k), bus_addr, t.e_addr);
            chk($sformatf("%s req%0d bus_we", tag, k), bus_we, {31'h0, t.e_we});
            if (t.e_we)
                chk($sformatf("%s req%0d bus_wdata", tag, k), bus_wdata, t.wd);
            if (t.drop)
                clear_strobes();
            bus_ack   = (k == t.n_req);
            bus_rdata = (k == t.n_req) ? t.rd : $urandom;
            @(posedge clk);
        end
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        chk({tag, " done stall"},   stall,   32'h0);
        chk({tag, " done bus_req"}, bus_req, 32'h0);
        clear_strobes();
        @(posedge clk);
        @(negedge clk);
        chk({tag, " instr"},  instr,  t.e_instr);
        chk({tag, " old_pc"}, old_pc, t.e_old_pc);
        chk({tag, " data"},   data,   t.e_data);
        chk({tag, " fault"},  fault,  32'h0);
        $display("txn %s: iw=%0b as=%0b mw=%0b addr=%h req_cycles=%0d drop=%0b instr=%h old_pc=%h data=%h",
                 tag, t.iw, t.as, t.mw, t.e_addr, t.n_req, t.drop, instr, old_pc, data);
    endtask

    // Builds a transaction and advances the register model from the access rules.
    task automatic make_vec(input int kind, input logic [31:0] pcv, input logic [31:0] alu,
                            input logic [31:0] rd, input int n, input bit drop, output vec_t t);
        t.iw    = (kind == 0);
        t.as    = (kind != 0);
        t.mw    = (kind == 2);
        t.pcv   = pcv;
        t.alu   = alu;
        t.wd    = $urandom;
        t.rd    = rd;
        t.n_req = n;
        t.drop  = drop;
        t.e_addr = t.iw ? pcv : alu;
        t.e_we   = (kind == 2);
        if (!drop) begin
            if (kind == 0) begin
                m_instr  = rd;
                m_old_pc = pcv;
            end else if (kind == 1) begin
                m_data = rd;
            end
        end
        t.e_instr  = m_instr;
        t.e_old_pc = m_old_pc;
        t.e_data   = m_data;
    endtask

    // Called at a negedge: pulses rst between clock edges and checks the cleared state.
    task automatic pulse_rst(input string tag);
        #2 rst = 1'b1;
        #1 check_zero(tag);
        #1 rst = 1'b0;
        m_instr  = 32'h0;
        m_old_pc = 32'h0;
        m_data   = 32'h0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,    32'h0,        32'h00500093, 1, 1'b0,
                    32'h100,  1'b0, 32'h00500093, 32'h100, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h104, 32'h2004, 32'h0,        32'hDEADBEEF, 4, 1'b0,
                    32'h2004, 1'b0, 32'h00500093, 32'h100, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h104, 32'h3000, 32'h12345678, 32'hCAFEF00D, 2, 1'b0,
                    32'h3000, 1'b1, 32'h00500093, 32'h100, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0,    32'h0,        32'h00A00113, 1, 1'b0,
                    32'h104,  1'b0, 32'h00A00113, 32'h104, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h108, 32'h2008, 32'h0,        32'h0BADF00D, 1, 1'b0,
                    32'h2008, 1'b0, 32'h00A00113, 32'h104, 32'h0BADF00D};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h108, 32'h4000, 32'h55,       32'h11111111, 2, 1'b0,
                    32'h108,  1'b0, 32'h11111111, 32'h108, 32'h0BADF00D};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h10C, 32'h0,    32'h0,        32'h22222222, 3, 1'b1,
                    32'h10C,  1'b0, 32'h11111111, 32'h108, 32'h0BADF00D};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h10C, 32'h2010, 32'h0,        32'h33333333, 2, 1'b1,
                    32'h2010, 1'b0, 32'h11111111, 32'h108, 32'h0BADF00D};

        rst = 1'b1;
        clear_strobes();
        pc = '0; alu_result = '0; write_data = '0;
        bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("reset stall", stall, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table; consecutive entries run back-to-back with no idle gap.
        for (int i = 0; i < 8; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        m_instr  = vecs[7].e_instr;
        m_old_pc = vecs[7].e_old_pc;
        m_data   = vecs[7].e_data;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            make_vec(op, $urandom & 32'h0000FFFC, $urandom, $urandom,
                     $urandom_range(1, 6), ($urandom_range(0, 7) == 0), v);
            run_vec($sformatf("rand%0d", i), v);
        end

        // Bus error on the second REQ cycle, with ack raised alongside it.
        adr_src = 1'b1; alu_result = 32'h5000;
        @(posedge clk);
        @(negedge clk);
        chk("err req1 bus_req", bus_req, 32'h1);
        @(posedge clk);
        @(negedge clk);
        bus_err = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hAAAA5555;
        @(posedge clk);
        @(negedge clk);
        bus_err = 1'b0; bus_ack = 1'b0;
        chk("err fault",   fault,   32'h1);
        chk("err bus_req", bus_req, 32'h0);
        chk("err stall",   stall,   32'h1);
        chk("err data",    data,    m_data);
        clear_strobes();
        repeat (3) @(negedge clk);
        chk("halt stall held", stall, 32'h1);
        chk("halt fault held", fault, 32'h1);
        $display("txn err-halt: fault=%0b stall=%0b", fault, stall);
        pulse_rst("halt rst");
        chk("after halt rst stall", stall, 32'h0);
        make_vec(0, 32'h400, 32'h0, 32'h00100073, 1, 1'b0, v);
        run_vec("post-rst fetch", v);

`ifdef MEM_TIMEOUT_EN
        // Ack on the last allowed REQ cycle still completes the transfer.
        make_vec(1, 32'h404, 32'h6000, 32'h44444444, TO, 1'b0, v);
        run_vec("ack at limit", v);
        ir_write = 1'b1; pc = 32'h200;
        @(posedge clk);
        cnt = 0;
        for (int c = 0; c < 3 * TO; c++) begin
            @(negedge clk);
            if (bus_req !== 1'b1) break;
            cnt++;
        end
        chk("timeout req cycles", cnt, TO);
        chk("timeout fault",   fault,   32'h1);
        chk("timeout stall",   stall,   32'h1);
        chk("timeout bus_req", bus_req, 32'h0);
        bus_ack = 1'b1; bus_rdata = 32'h99999999;
        repeat (3) @(negedge clk);
        bus_ack = 1'b0;
        chk("late ack bus_req", bus_req, 32'h0);
        chk("late ack fault",   fault,   32'h1);
        chk("late ack stall",   stall,   32'h1);
        chk("late ack instr",   instr,   m_instr);
        $display("txn timeout: req_cycles=%0d fault=%0b", cnt, fault);
        clear_strobes();
        pulse_rst("timeout rst");
`else
        // Without the timeout a long wait simply completes.
        make_vec(1, 32'h404, 32'h6000, 32'h44444444, 30, 1'b0, v);
        run_vec("long wait", v);
`endif

        // Reset in the middle of a fetch.
        ir_write = 1'b1; pc = 32'h300;
        @(posedge clk);
        @(negedge clk);
        chk("midreq bus_req", bus_req, 32'h1);
        #2 rst = 1'b1;
        #1 chk("midreq rst bus_req", bus_req, 32'h0);
        chk("midreq rst instr", instr, 32'h0);
        chk("midreq rst old_pc", old_pc, 32'h0);
        clear_strobes();
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midreq after instr", instr, 32'h0);
        chk("midreq after bus_req", bus_req, 32'h0);
        $display("txn rst-midreq: bus_req=%0b instr=%h", bus_req, instr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
